modulo_bandeja_rolhas_param: RTL

//  Parametrised cork-tray controller for the filling/sealing line: holds the tray cork count,

---
 rtl/modulo_bandeja_rolhas_param_pkg.sv | 23 ++
 rtl/modulo_bandeja_rolhas_param_conversor.sv | 81 ++++++++
 rtl/modulo_bandeja_rolhas_param.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/modulo_bandeja_rolhas_param_pkg.sv
// Shared types and default constants for the cork-tray controller.
// Load FSM state encoding plus a BCD digit-adjust helper for the converter.
package modulo_bandeja_rolhas_param_pkg;

    typedef enum logic [1:0] {
        S_OCIOSO   = 2'd0,
        S_AVALIA   = 2'd1,
        S_CONFIRMA = 2'd2,
        S_ESPERA   = 2'd3
    } estado_carga_t;

    localparam int LARGURA_PADRAO    = 7;
    localparam int CAPACIDADE_PADRAO = 99;
    localparam int MINIMO_PADRAO     = 5;
    localparam int REPOSICAO_PADRAO  = 20;
    localparam int DIGITOS_PADRAO    = 2;

    // Double-dabble correction: a digit of 5 or more becomes >= 8 before the shift.
    function automatic logic [3:0] ajusta_digito(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/modulo_bandeja_rolhas_param_conversor.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// A start pulse always restarts; the previous result stays on bcd until the new latch.
module modulo_conversor_bin_bcd_seq
    import modulo_bandeja_rolhas_param_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int DIGITOS = DIGITOS_PADRAO
) (
    input  logic                 clk,
    input  logic                 Nclr,
    input  logic                 inicio,
    input  logic [LARGURA-1:0]   bin,
    output logic [4*DIGITOS-1:0] bcd,
    output logic                 pronto
);

    localparam int CW = $clog2(LARGURA + 1);
    localparam int BW = 4 * DIGITOS;

    logic [LARGURA-1:0] desl_q, desl_d;
    logic [BW-1:0]      acc_q, acc_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ocupado_q, ocupado_d;
    logic               pronto_q, pronto_d;
    logic [BW-1:0]      acc_ajustado;

    always_comb begin
        acc_ajustado = acc_q;
        for (int i = 0; i < DIGITOS; i++) begin
            acc_ajustado[4*i +: 4] = ajusta_digito(acc_q[4*i +: 4]);
        end

        desl_d    = desl_q;
        acc_d     = acc_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ocupado_d = ocupado_q;
        pronto_d  = pronto_q;

        if (inicio) begin
            desl_d    = bin;
            acc_d     = '0;
            cnt_d     = '0;
            ocupado_d = 1'b1;
            pronto_d  = 1'b0;
        end else if (ocupado_q) begin
            if (cnt_q == CW'(LARGURA)) begin
                bcd_d     = acc_q;
                ocupado_d = 1'b0;
                pronto_d  = 1'b1;
            end else begin
                acc_d  = {acc_ajustado[BW-2:0], desl_q[LARGURA-1]};
                desl_d = desl_q << 1;
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            desl_q    <= '0;
            acc_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b1;
        end else begin
            desl_q    <= desl_d;
            acc_q     <= acc_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign bcd    = bcd_q;
    assign pronto = pronto_q;

endmodule

// File: rtl/modulo_bandeja_rolhas_param.sv
// Cork-tray controller: count register, valve-edge consumption, req/ack batch load FSM, flags, BCD.
// Define REPOSICAO_AUTO_EN to enable automatic refill of REPOSICAO corks when the tray runs low.
module modulo_bandeja_rolhas_param
    import modulo_bandeja_rolhas_param_pkg::*;
#(
    parameter int LARGURA    = LARGURA_PADRAO,
    parameter int CAPACIDADE = CAPACIDADE_PADRAO,
    parameter int MINIMO     = MINIMO_PADRAO,
    parameter int REPOSICAO  = REPOSICAO_PADRAO,
    parameter int DIGITOS    = DIGITOS_PADRAO
) (
    input  logic                 clk,
    input  logic                 Nclr,
    input  logic                 enable,
    input  logic                 ve,
    input  logic                 req_carga,
    input  logic [LARGURA-1:0]   lote,
    output logic                 ack_carga,
    output logic                 erro_lote,
    output logic                 erro_consumo,
    output logic [LARGURA-1:0]   qtd,
    output logic                 ro,
    output logic                 min_r,
    output logic                 cheio,
    output logic [4*DIGITOS-1:0] bcd,
    output logic                 bcd_valido
);

`ifdef REPOSICAO_AUTO_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    localparam logic [LARGURA+1:0] CAP_EXT = (LARGURA+2)'(CAPACIDADE);
    localparam logic [LARGURA-1:0] CAP_Q   = LARGURA'(CAPACIDADE);
    localparam logic [LARGURA-1:0] MIN_Q   = LARGURA'(MINIMO);
    localparam logic [LARGURA-1:0] REP_Q   = LARGURA'(REPOSICAO);

    estado_carga_t      estado_q, estado_d;
    logic [LARGURA-1:0] qtd_q, qtd_d;
    logic               ve_q, ve_d;
    logic               auto_q, auto_d;
    logic               ack_q, ack_d;
    logic               erro_lote_q, erro_lote_d;
    logic               erro_consumo_q, erro_consumo_d;
    logic               ro_q, ro_d;
    logic               min_r_q, min_r_d;
    logic               cheio_q, cheio_d;

    logic               borda_ve;
    logic               consumo;
    logic [LARGURA-1:0] lote_efetivo;
    logic [LARGURA+1:0] soma;
    logic               inicio_conv;

    always_comb begin
        ve_d           = ve;
        borda_ve       = ve & ~ve_q;
        consumo        = enable & borda_ve & (qtd_q != '0);
        erro_consumo_d = enable & borda_ve & (qtd_q == '0);

        lote_efetivo = auto_q ? REP_Q : lote;
        // Extra headroom bits keep a large batch from wrapping past the capacity check.
        soma = {2'b00, qtd_q} + {2'b00, lote_efetivo} - {{(LARGURA+1){1'b0}}, consumo};

        qtd_d       = qtd_q - LARGURA'(consumo);
        estado_d    = estado_q;
        auto_d      = auto_q;
        ack_d       = 1'b0;
        erro_lote_d = 1'b0;

        case (estado_q)
            S_OCIOSO: begin
                if (req_carga && enable) begin
                    estado_d = S_AVALIA;
                    auto_d   = 1'b0;
                end else if (AUTO_EN && enable && min_r_q) begin
                    estado_d = S_AVALIA;
                    auto_d   = 1'b1;
                end
            end
            S_AVALIA: estado_d = S_CONFIRMA;
            S_CONFIRMA: begin
                if (soma <= CAP_EXT) begin
                    qtd_d = soma[LARGURA-1:0];
                    ack_d = ~auto_q;
                end else begin
                    erro_lote_d = 1'b1;
                end
                estado_d = S_ESPERA;
            end
            S_ESPERA: begin
                if (!req_carga) estado_d = S_OCIOSO;
            end
            default: estado_d = S_OCIOSO;
        endcase

        ro_d        = (qtd_d == '0);
        min_r_d     = (qtd_d < MIN_Q);
        cheio_d     = (qtd_d == CAP_Q);
        inicio_conv = (qtd_d != qtd_q);
    end

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            estado_q       <= S_OCIOSO;
            qtd_q          <= '0;
            ve_q           <= 1'b0;
            auto_q         <= 1'b0;
            ack_q          <= 1'b0;
            erro_lote_q    <= 1'b0;
            erro_consumo_q <= 1'b0;
            ro_q           <= 1'b1;
            min_r_q        <= 1'b1;
            cheio_q        <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            qtd_q          <= qtd_d;
            ve_q           <= ve_d;
            auto_q         <= auto_d;
            ack_q          <= ack_d;
            erro_lote_q    <= erro_lote_d;
            erro_consumo_q <= erro_consumo_d;
            ro_q           <= ro_d;
            min_r_q        <= min_r_d;
            cheio_q        <= cheio_d;
        end
    end

    modulo_conversor_bin_bcd_seq #(
        .LARGURA (LARGURA),
        .DIGITOS (DIGITOS)
    ) u_conversor (
        .clk    (clk),
        .Nclr   (Nclr),
        .inicio (inicio_conv),
        .bin    (qtd_d),
        .bcd    (bcd),
        .pronto (bcd_valido)
    );

    assign ack_carga    = ack_q;
    assign erro_lote    = erro_lote_q;
    assign erro_consumo = erro_consumo_q;
    assign qtd          = qtd_q;
    assign ro           = ro_q;
    assign min_r        = min_r_q;
    assign cheio        = cheio_q;

endmodule
